// File: rtl/vec_regfile_seq.sv
// rtl/vec_regfile_seq.sv - vector register file with LMUL grouping, multi-beat group-write sequencer
// and registered three-port group reads.
module vec_regfile_seq #(
  parameter int VLEN       = 512,
  parameter int NUM_REGS   = 32,
  parameter int MAX_LMUL   = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [3:0]                     wr_lmul,
  input  logic [VLEN*MAX_LMUL-1:0]       wdata,
  input  logic [VLEN*MAX_LMUL/8-1:0]     wr_be,
  output logic                           wr_done,
  output logic                           wr_err,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          raddr_1,
  input  logic [ADDR_WIDTH-1:0]          raddr_2,
  input  logic [ADDR_WIDTH-1:0]          raddr_d,
  input  logic [3:0]                     rd_lmul,
  output logic [VLEN*MAX_LMUL-1:0]       rdata_1,
  output logic [VLEN*MAX_LMUL-1:0]       rdata_2,
  output logic [VLEN*MAX_LMUL-1:0]       dst_data,
  output logic                           rd_valid,
  output logic                           rd_err,
  output logic                           busy
);

  localparam int MAX_VLEN = VLEN * MAX_LMUL;
  localparam int VBYTES   = VLEN / 8;
  localparam int AW1      = ADDR_WIDTH + 1;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                  state_q, state_d;
  logic [VLEN-1:0]         regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [3:0]              lmul_q;
  logic [MAX_VLEN-1:0]     wdata_q;
  logic [MAX_VLEN/8-1:0]   be_q;
  logic [2:0]              beat_q;
  logic                    accept, reject, commit, last_beat, beat_is_last, wr_legal;
  logic [VLEN-1:0]         beat_data;
  logic [VBYTES-1:0]       beat_be;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic                    rd_legal;
  logic [MAX_VLEN-1:0]     grp_1, grp_2, grp_d;

  // Group is legal when size is 1/2/4/8, base is size-aligned and the group fits in the file.
  function automatic logic group_legal(input logic [ADDR_WIDTH-1:0] base, input logic [3:0] lmul);
    logic            size_ok;
    logic [AW1-1:0]  span_end;
    size_ok  = ((lmul == 4'd1) || (lmul == 4'd2) || (lmul == 4'd4) || (lmul == 4'd8))
               && (lmul <= 4'(MAX_LMUL));
    span_end = {1'b0, base} + AW1'(lmul);
    return size_ok
           && ((base & ADDR_WIDTH'(lmul - 4'd1)) == '0)
           && (span_end <= AW1'(NUM_REGS));
  endfunction

  assign wr_legal     = group_legal(waddr, wr_lmul);
  assign rd_legal     = group_legal(raddr_1, rd_lmul) && group_legal(raddr_2, rd_lmul)
                        && group_legal(raddr_d, rd_lmul);
  assign beat_is_last = ({1'b0, beat_q} == (lmul_q - 4'd1));
  assign beat_data    = wdata_q[int'(beat_q)*VLEN +: VLEN];
  assign beat_be      = be_q[int'(beat_q)*VBYTES +: VBYTES];
  assign beat_addr    = base_q + ADDR_WIDTH'(beat_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    commit    = 1'b0;
    last_beat = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          if (wr_legal) begin
            accept  = 1'b1;
            state_d = S_WRITE;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        busy   = 1'b1;
        commit = 1'b1;
        if (beat_is_last) begin
          last_beat = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The whole request is captured on accept so the write port is free while beats drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q  <= '0;
      lmul_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      beat_q  <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_done <= last_beat;
      wr_err  <= reject;
      if (accept) begin
        base_q  <= waddr;
        lmul_q  <= wr_lmul;
        wdata_q <= wdata;
        be_q    <= wr_be;
        beat_q  <= '0;
      end else if (commit) begin
        beat_q  <= beat_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (commit) begin
      for (int b = 0; b < VBYTES; b++) begin
        if (beat_be[b]) regs[beat_addr][b*8 +: 8] <= beat_data[b*8 +: 8];
      end
    end
  end

  // Group gather reads the pre-edge array, so a read colliding with a commit sees old data.
  always_comb begin
    grp_1 = '0;
    grp_2 = '0;
    grp_d = '0;
    for (int k = 0; k < MAX_LMUL; k++) begin
      if (4'(k) < rd_lmul) begin
        grp_1[k*VLEN +: VLEN] = regs[raddr_1 + ADDR_WIDTH'(k)];
        grp_2[k*VLEN +: VLEN] = regs[raddr_2 + ADDR_WIDTH'(k)];
        grp_d[k*VLEN +: VLEN] = regs[raddr_d + ADDR_WIDTH'(k)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_1  <= '0;
      rdata_2  <= '0;
      dst_data <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      rd_err   <= !rd_legal;
      rdata_1  <= rd_legal ? grp_1 : '0;
      rdata_2  <= rd_legal ? grp_2 : '0;
      dst_data <= rd_legal ? grp_d : '0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_regfile_seq.sv
// tb/tb_vec_regfile_seq.sv - randomized self-checking bench for vec_regfile_seq against an
// array model of the register file.
module tb_vec_regfile_seq;

  localparam int VLEN = 512;
  localparam int NR   = 32;
  localparam int ML   = 8;
  localparam int AW   = 5;
  localparam int MV   = VLEN * ML;
  localparam int VB   = VLEN / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [AW-1:0]     waddr = '0;
  logic [3:0]        wr_lmul = '0;
  logic [MV-1:0]     wdata = '0;
  logic [MV/8-1:0]   wr_be = '0;
  logic              wr_done, wr_err;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     raddr_1 = '0, raddr_2 = '0, raddr_d = '0;
  logic [3:0]        rd_lmul = '0;
  logic [MV-1:0]     rdata_1, rdata_2, dst_data;
  logic              rd_valid, rd_err, busy;

  int checks = 0;
  int errors = 0;
  logic [VLEN-1:0] mem [NR];

  always #5 clk = ~clk;

  vec_regfile_seq #(.VLEN(VLEN), .NUM_REGS(NR), .MAX_LMUL(ML), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .waddr(waddr),
    .wr_lmul(wr_lmul), .wdata(wdata), .wr_be(wr_be), .wr_done(wr_done), .wr_err(wr_err),
    .rd_en(rd_en), .raddr_1(raddr_1), .raddr_2(raddr_2), .raddr_d(raddr_d), .rd_lmul(rd_lmul),
    .rdata_1(rdata_1), .rdata_2(rdata_2), .dst_data(dst_data), .rd_valid(rd_valid),
    .rd_err(rd_err), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(int a, int l);
    return (l == 1 || l == 2 || l == 4 || l == 8) && (a % l == 0) && (a + l <= NR);
  endfunction

  function automatic logic [MV-1:0] group(int a, int l);
    logic [MV-1:0] g = '0;
    if (legal(a, l))
      for (int k = 0; k < l; k++) g[k*VLEN +: VLEN] = mem[a+k];
    return g;
  endfunction

  function automatic logic [63:0] fold(logic [MV-1:0] v);
    logic [63:0] f = '0;
    for (int i = 0; i < MV/64; i++) f = {f[62:0], f[63]} ^ v[i*64 +: 64];
    return f;
  endfunction

  function automatic logic [MV-1:0] rand_vec();
    logic [MV-1:0] v;
    for (int i = 0; i < MV/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [MV/8-1:0] rand_be();
    logic [MV/8-1:0] v;
    for (int i = 0; i < MV/256; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int pick_lmul();
    int r = $urandom_range(0, 9);
    if (r < 8) return 1 << (r % 4);
    return (r == 8) ? 3 : 6;
  endfunction

  function automatic int pick_addr(int l);
    int a = $urandom_range(0, NR-1);
    if ($urandom_range(0, 3) != 0 && l > 0) a = a - (a % l);
    return a;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NR; r++) mem[r] = '0;
  endtask

  task automatic do_read(input string name, input int a1, input int a2, input int ad, input int l);
    logic [MV-1:0] e1, e2, ed;
    bit ok;
    ok = legal(a1, l) && legal(a2, l) && legal(ad, l);
    e1 = ok ? group(a1, l) : '0;
    e2 = ok ? group(a2, l) : '0;
    ed = ok ? group(ad, l) : '0;
    rd_en = 1'b1; raddr_1 = AW'(a1); raddr_2 = AW'(a2); raddr_d = AW'(ad); rd_lmul = 4'(l);
    tick();
    rd_en = 1'b0; raddr_1 = AW'($urandom); raddr_2 = AW'($urandom); raddr_d = AW'($urandom);
    rd_lmul = 4'($urandom);
    checks++;
    if (rd_valid !== 1'b1 || rd_err !== !ok) begin
      errors++;
      $display("FAIL %s rd_flags valid=%0b err=%0b required valid=1 err=%0b", name, rd_valid, rd_err, !ok);
    end
    checks++;
    if ({rdata_1, rdata_2, dst_data} !== {e1, e2, ed}) begin
      errors++;
      $display("FAIL %s rd_data fold r1=%h r2=%h d=%h required %h %h %h", name,
               fold(rdata_1), fold(rdata_2), fold(dst_data), fold(e1), fold(e2), fold(ed));
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rdata_1 !== e1) begin
      errors++;
      $display("FAIL %s rd_hold valid=%0b err=%0b r1=%h required 0 0 %h", name, rd_valid, rd_err,
               fold(rdata_1), fold(e1));
    end
  endtask

  task automatic do_write(input string name, input int a, input int l, input logic [MV-1:0] data,
                          input logic [MV/8-1:0] be, input int rd_beat, input int abort_beat);
    logic [MV-1:0] exp_rd;
    wr_valid = 1'b1; waddr = AW'(a); wr_lmul = 4'(l); wdata = data; wr_be = be;
    tick();
    wr_valid = 1'b0;
    if (!legal(a, l)) begin
      checks++;
      if (wr_err !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1 || wr_done !== 1'b0) begin
        errors++;
        $display("FAIL %s reject err=%0b busy=%0b ready=%0b done=%0b required 1 0 1 0", name,
                 wr_err, busy, wr_ready, wr_done);
      end
      tick();
      checks++;
      if (wr_err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s reject_pulse err=%0b busy=%0b required 0 0", name, wr_err, busy);
      end
      return;
    end
    for (int k = 0; k < l; k++) begin
      checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b1 || wr_done !== 1'b0 || wr_err !== 1'b0) begin
        errors++;
        $display("FAIL %s beat%0d ready=%0b busy=%0b done=%0b err=%0b required 0 1 0 0", name, k,
                 wr_ready, busy, wr_done, wr_err);
      end
      if (k == abort_beat) begin
        #2 reset = 1'b0;
        #1;
        clear_model();
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || wr_done !== 1'b0 || rd_valid !== 1'b0
            || rdata_1 !== '0) begin
          errors++;
          $display("FAIL %s abort ready=%0b busy=%0b done=%0b rv=%0b r1=%h required 1 0 0 0 0", name,
                   wr_ready, busy, wr_done, rd_valid, fold(rdata_1));
        end
        #2 reset = 1'b1;
        return;
      end
      wr_valid = (k < l - 1) ? 1'($urandom) : 1'b0;
      waddr = AW'($urandom); wr_lmul = 4'($urandom); wdata = rand_vec(); wr_be = rand_be();
      if (k == rd_beat) begin
        rd_en = 1'b1; raddr_1 = AW'(a); raddr_2 = AW'(a); raddr_d = AW'(a); rd_lmul = 4'(l);
        exp_rd = group(a, l);
      end
      tick();
      for (int b = 0; b < VB; b++)
        if (be[k*VB + b]) mem[a+k][b*8 +: 8] = data[k*VLEN + b*8 +: 8];
      wr_valid = 1'b0;
      if (k == rd_beat) begin
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rdata_1 !== exp_rd) begin
          errors++;
          $display("FAIL %s collide rv=%0b re=%0b r1=%h required 1 0 %h", name, rd_valid, rd_err,
                   fold(rdata_1), fold(exp_rd));
        end
      end
    end
    checks++;
    if (wr_done !== 1'b1 || wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done done=%0b ready=%0b busy=%0b required 1 1 0", name, wr_done, wr_ready, busy);
    end
    tick();
    checks++;
    if (wr_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse done=%0b required 0", name, wr_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_model();
    tick(); tick();
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || wr_done !== 1'b0 || wr_err !== 1'b0
        || rd_valid !== 1'b0 || rd_err !== 1'b0 || {rdata_1, rdata_2, dst_data} !== '0) begin
      errors++;
      $display("FAIL reset_state ready=%0b busy=%0b done=%0b err=%0b rv=%0b re=%0b required 1 0 0 0 0 0",
               wr_ready, busy, wr_done, wr_err, rd_valid, rd_err);
    end
    reset = 1'b1;
    tick();
    do_read("reset_read", 0, 31, 5, 1);
  endtask

  task automatic test_group_write();
    logic [MV-1:0] d = rand_vec();
    do_write("grp4", 8, 4, d, '1, -1, -1);
    do_read("grp4_rd", 8, 0, 28, 4);
    checks++;
    if (rdata_1 !== {{(MV-4*VLEN){1'b0}}, d[4*VLEN-1:0]}) begin
      errors++;
      $display("FAIL grp4_direct r1=%h required %h", fold(rdata_1), fold({{(MV-4*VLEN){1'b0}}, d[4*VLEN-1:0]}));
    end
    do_read("grp4_rd9", 9, 10, 11, 1);
    checks++;
    if (rdata_1 !== {{(MV-VLEN){1'b0}}, d[2*VLEN-1:VLEN]}) begin
      errors++;
      $display("FAIL grp4_beatB r1=%h required %h", fold(rdata_1), fold({{(MV-VLEN){1'b0}}, d[2*VLEN-1:VLEN]}));
    end
  endtask

  task automatic test_byte_enable();
    logic [MV/8-1:0] be = '0;
    be[3:0] = 4'hF;
    do_write("be", 3, 1, '1, be, -1, -1);
    do_read("be_rd", 3, 3, 3, 1);
    checks++;
    if (rdata_1 !== MV'(32'hFFFF_FFFF)) begin
      errors++;
      $display("FAIL be_direct r1=%h required %h", fold(rdata_1), fold(MV'(32'hFFFF_FFFF)));
    end
  endtask

  task automatic test_illegal();
    do_write("ill_mis", 6, 4, rand_vec(), '1, -1, -1);
    do_write("ill_size", 0, 3, rand_vec(), '1, -1, -1);
    do_read("ill_unchanged", 4, 0, 8, 4);
    do_read("ill_rd", 6, 0, 0, 4);
  endtask

  task automatic test_collision();
    do_write("col_seed", 16, 8, rand_vec(), '1, -1, -1);
    do_write("col_write", 16, 8, rand_vec(), rand_be(), 0, -1);
    do_read("col_after", 16, 16, 16, 8);
  endtask

  task automatic test_random();
    int l, a1, a2, ad;
    for (int i = 0; i < 40; i++) begin
      l = pick_lmul();
      if ($urandom_range(0, 2) != 0) begin
        a1 = pick_addr(l);
        do_write("rnd_wr", a1, l, rand_vec(), ($urandom_range(0, 1) == 0) ? '1 : rand_be(), -1, -1);
      end else begin
        a1 = pick_addr(l); a2 = pick_addr(l); ad = pick_addr(l);
        do_read("rnd_rd", a1, a2, ad, l);
      end
    end
  endtask

  task automatic test_reset_abort();
    do_write("abort", 24, 8, rand_vec(), '1, -1, 3);
    tick();
    checks++;
    if (wr_done !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after done=%0b ready=%0b busy=%0b required 0 1 0", wr_done, wr_ready, busy);
    end
    do_read("abort_rd0", 0, 8, 16, 8);
    do_read("abort_rd24", 24, 24, 24, 8);
  endtask

  initial begin
    test_reset();
    test_group_write();
    test_byte_enable();
    test_illegal();
    test_collision();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_regfile_seq.md
Name: vec_regfile_seq

Overview:
Parametrised successor to the vector register file. It holds NUM_REGS registers of VLEN bits and supports LMUL register grouping. It adds a handshaked, multi-beat group-write sequencer that writes one VLEN register per cycle with byte enables, plus registered (1-cycle) group reads with an error flag. It sits between the vector decode/issue stage and the execution lanes, sourcing operands (rdata_1/rdata_2/dst_data) and sinking lane results.

Parameters:
VLEN, 512, bits per architectural vector register
NUM_REGS, 32, number of vector registers (power of 2)
MAX_LMUL, 8, largest group size; MAX_VLEN = VLEN*MAX_LMUL
ADDR_WIDTH, 5, register index width = $clog2(NUM_REGS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
wr_valid  in  1  group-write request
wr_ready  out  1  sequencer idle, can accept a request
waddr  in  ADDR_WIDTH  base register of the write group
wr_lmul  in  4  write group size: 1, 2, 4 or 8
wdata  in  MAX_VLEN  group data; beat k = wdata[k*VLEN +: VLEN]
wr_be  in  MAX_VLEN/8  byte enables; beat k = wr_be[k*VLEN/8 +: VLEN/8]
wr_done  out  1  one-cycle pulse after the last beat commits
wr_err  out  1  one-cycle pulse for a rejected write
rd_en  in  1  read request
raddr_1, raddr_2, raddr_d  in  ADDR_WIDTH  base registers for the three read groups
rd_lmul  in  4  read group size: 1, 2, 4 or 8
rdata_1, rdata_2, dst_data  out  MAX_VLEN  registered group read data
rd_valid  out  1  read data valid, one cycle after rd_en
rd_err  out  1  registered; read request was illegal
busy  out  1  write sequencer not idle

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear to 0; FSM goes to IDLE.
  - Outputs: wr_ready=1, busy=0, wr_done=0, wr_err=0, rd_valid=0, rd_err=0.
  - rdata_1, rdata_2 and dst_data clear to 0.
  - Reset during a write aborts it; beats not yet committed are lost.
- Legality for a write or read group with base a and size l:
  - l must be in {1,2,4,8};
  - a mod l must equal 0;
  - a + l must be <= NUM_REGS.
- FSM states: IDLE, WRITE.
  - IDLE: wr_ready=1.
    - wr_valid with a legal request: latch waddr, wr_lmul, wdata and wr_be; beat counter=0; go to WRITE.
    - wr_valid with an illegal request: stay in IDLE; wr_err=1 for the next cycle; no register changes.
  - WRITE: wr_ready=0, busy=1.
    - Each edge commits beat k to register base+k. Only bytes with the enable set are updated; other bytes keep their value.
    - After beat l-1, return to IDLE; wr_done=1 for that one cycle.
    - Inputs to the write port are ignored while in WRITE.
- Write timing: request accepted at edge E0; beats commit at edges E1..El; wr_done and wr_ready are high in the cycle after El. Occupancy is l+1 cycles per write.
- Reads:
  - rd_en sampled at edge T. From T+ onward, the three outputs hold the l-register groups, concatenated with the lowest register in the LSBs.
  - Bits at and above l*VLEN are 0.
  - rd_valid=1 for one cycle.
  - Without rd_en, rd_valid=0 and the data outputs hold their values.
- Illegal read: rd_err=1, rd_valid=1, and all three data outputs are 0.
- Read/write collision on the same edge: the read returns the pre-edge contents (old data). No bypass.
- Reads are fully independent of the write sequencer and are always accepted.
- No widening of arithmetic; the beat counter is 3 bits.

Test Plan:
- Reset, then rd_en with raddr_1=0, raddr_2=31, raddr_d=5, rd_lmul=1 -> rd_valid=1 next cycle; all outputs 0; rd_err=0.
- Write waddr=8, wr_lmul=4, wdata=4 beats of A,B,C,D (VLEN each), wr_be all ones -> wr_ready low for 4 cycles; wr_done in cycle 5. Then read raddr_1=8, rd_lmul=4 -> {D,C,B,A}; read raddr_1=9, rd_lmul=1 -> B.
- Write waddr=3, wr_lmul=1, wdata=all-ones, wr_be=0x...0F over a register holding 0 -> register 3 = 0x...FFFFFFFF in bytes 0-3 only; rest 0.
- Write waddr=6 with wr_lmul=4 (misaligned), then waddr=0 with wr_lmul=3 -> wr_err pulse each time; busy stays 0; registers unchanged. Read raddr_1=6 with rd_lmul=4 -> rd_err=1, data 0.
- During an 8-beat write to waddr=16, issue a read of raddr_1=16, rd_lmul=8 on the same edge as beat 0 commits -> old value returned. The same read after wr_done -> new value.
- Assert reset during beat 3 of an 8-beat write to 24 -> all registers 0; wr_ready=1; no wr_done pulse.
